// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the JTAG host engine.
//   - command op encodings carried on cmd_op
//   - host FSM state encoding
//   - TMS=1 run length of the TAP reset sequence
//   - scan length normalisation helper
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_NOP   = 2'd3
  } jtag_op_e;

  typedef enum logic [3:0] {
    IDLE,
    RESET_SEQ,
    SEL,
    CAP,
    ENTER,
    SHIFT,
    UPD,
    RTI,
    IDLE_WAIT
  } host_state_e;

  localparam int unsigned RESET_TMS_CYCLES = 5;

  // Zero-length scans shift one bit; oversize scans stop at max_len.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider for the JTAG host.
//   CLK, rst    : system clock, synchronous active-high reset
//   en          : run the divider; when low TCK is held low and the count at 0
//   tck         : registered JTAG clock, low for CLK_DIV CLKs then high for CLK_DIV
//   tck_rise_c  : high in the CLK cycle whose closing edge raises TCK
//   tck_fall_c  : high in the CLK cycle whose closing edge drops TCK
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic tck_rise_c,
  output logic tck_fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             wrap_c;

  assign wrap_c     = en && (div_q == DIV_LAST);
  assign tck_rise_c = wrap_c && !tck;
  assign tck_fall_c = wrap_c && tck;

  // Half-period counter; TCK toggles each time it wraps.
  always_ff @(posedge CLK) begin
    if (rst || !en) begin
      div_q <= '0;
      tck   <= 1'b0;
    end else if (wrap_c) begin
      div_q <= '0;
      tck   <= ~tck;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/jtag_host.sv
// jtag_host: master-side JTAG engine. Takes one command at a time (TAP reset,
// IR scan, DR scan), walks the TAP from Run-Test/Idle and back, and returns
// the TDO bits captured during Shift.
//   CLK, rst                    : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_op/cmd_len/cmd_data     : op, scan length, bits to shift (LSB first)
//   cmd_idle                    : extra Run-Test/Idle TCKs (JTAG_HOST_IDLE_EN only)
//   rsp_valid/rsp_data          : completion pulse, captured bits (first in bit 0)
//   TCK/TMS/TDI/TDO             : JTAG pins
// Optional feature macro: JTAG_HOST_IDLE_EN.
module jtag_host
  import jtag_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_HOST_IDLE_EN
  input  logic [7:0]         cmd_idle,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  // Per-state TCK counter must cover scan length, IR select and idle count.
  localparam int unsigned CNT_W = (LEN_W > 8) ? LEN_W : 8;

  host_state_e        state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               is_ir_q, is_ir_d;
  logic               rst_rsp_q, rst_rsp_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
`ifdef JTAG_HOST_IDLE_EN
  logic [7:0]         idle_q, idle_d;
`endif

  logic               tck_en_c;
  logic               tck_rise_c;
  logic               tck_fall_c;
  logic               done_c;
  logic [LEN_W-1:0]   len_eff_c;
  logic [CNT_W-1:0]   last_bit_c;
  logic [MAX_LEN-1:0] data_sh_c;

  assign tck_en_c   = (state_q != IDLE);
  assign len_eff_c  = LEN_W'(clamp_len(32'(cmd_len), MAX_LEN));
  assign last_bit_c = CNT_W'(len_q - LEN_W'(1));
  assign data_sh_c  = data_q >> 1;

  jtag_tck_gen #(
    .CLK_DIV    (CLK_DIV)
  ) u_tck_gen (
    .CLK        (CLK),
    .rst        (rst),
    .en         (tck_en_c),
    .tck        (TCK),
    .tck_rise_c (tck_rise_c),
    .tck_fall_c (tck_fall_c)
  );

  // Next-state and next-output logic; the FSM moves only on TCK falling edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    is_ir_d     = is_ir_q;
    rst_rsp_d   = rst_rsp_q;
    data_d      = data_q;
    cap_d       = cap_q;
    mask_d      = mask_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef JTAG_HOST_IDLE_EN
    idle_d      = idle_q;
`endif
    done_c      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          len_d       = len_eff_c;
          data_d      = cmd_data;
          cap_d       = '0;
          mask_d      = MAX_LEN'(1);
          bit_cnt_d   = '0;
          is_ir_d     = (cmd_op == OP_IR);
`ifdef JTAG_HOST_IDLE_EN
          idle_d      = cmd_idle;
`endif
          case (jtag_op_e'(cmd_op))
            OP_RESET: begin
              state_d   = RESET_SEQ;
              tms_d     = 1'b1;
              rst_rsp_d = 1'b1;
            end
            OP_IR, OP_DR: begin
              state_d = SEL;
              tms_d   = 1'b1;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end

      // Five TMS=1 TCKs reach Test-Logic-Reset, one TMS=0 lands in Run-Test/Idle.
      RESET_SEQ: begin
        if (tck_fall_c) begin
          if (bit_cnt_q == CNT_W'(RESET_TMS_CYCLES)) begin
            if (rst_rsp_q) begin
              done_c    = 1'b1;
              rst_rsp_d = 1'b0;
            end else begin
              state_d     = IDLE;
              cmd_ready_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tms_d     = (bit_cnt_q < CNT_W'(RESET_TMS_CYCLES - 1));
          end
        end
      end

      // IR scans pass through Select-DR then Select-IR, so hold TMS=1 twice.
      SEL: begin
        if (tck_fall_c) begin
          if (is_ir_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CNT_W'(1);
          end else begin
            state_d   = CAP;
            tms_d     = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end

      CAP: begin
        if (tck_fall_c) begin
          state_d = ENTER;
        end
      end

      ENTER: begin
        if (tck_fall_c) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tdi_d     = data_q[0];
          tms_d     = (len_q == LEN_W'(1));
        end
      end

      // One capture per rising TCK; the last bit carries TMS=1 into Exit1.
      SHIFT: begin
        if (tck_rise_c) begin
          if (TDO) begin
            cap_d = cap_q | mask_q;
          end
          mask_d = mask_q << 1;
        end
        if (tck_fall_c) begin
          if (bit_cnt_q == last_bit_c) begin
            state_d = UPD;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            data_d    = data_sh_c;
            tdi_d     = data_sh_c[0];
            tms_d     = ((bit_cnt_q + CNT_W'(1)) == last_bit_c);
          end
        end
      end

      UPD: begin
        if (tck_fall_c) begin
          state_d = RTI;
          tms_d   = 1'b0;
        end
      end

      RTI: begin
        if (tck_fall_c) begin
`ifdef JTAG_HOST_IDLE_EN
          if (idle_q != 8'd0) begin
            state_d   = IDLE_WAIT;
            bit_cnt_d = '0;
          end else begin
            done_c = 1'b1;
          end
`else
          done_c = 1'b1;
`endif
        end
      end

`ifdef JTAG_HOST_IDLE_EN
      // Extra Run-Test/Idle TCKs with TMS held low.
      IDLE_WAIT: begin
        if (tck_fall_c) begin
          if (bit_cnt_q == CNT_W'(idle_q - 8'd1)) begin
            done_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion: back to IDLE with a one-cycle response; ready follows a CLK later.
    if (done_c) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_q;
      cmd_ready_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= RESET_SEQ;
      bit_cnt_q   <= '0;
      len_q       <= LEN_W'(1);
      is_ir_q     <= 1'b0;
      rst_rsp_q   <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      mask_q      <= MAX_LEN'(1);
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef JTAG_HOST_IDLE_EN
      idle_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      is_ir_q     <= is_ir_d;
      rst_rsp_q   <= rst_rsp_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef JTAG_HOST_IDLE_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule
